mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit, between the EX/MEM register and the MEM/WB register.
- Converts the pipeline's load/store request (ALU address, store data, size, sign) into a req/ack transaction on the data-memory bus.
- Stalls the pipeline while the access is outstanding.
- Returns the aligned, extended load word as RD, which feeds the MEM/WB register's RD input.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles before the access is aborted as a bus error.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MemSignedM  in  1  sign-extend sub-word loads
- ALUOutM  in  32  effective byte address
- WriteDataM  in  32  store data, right-justified
- RD  out  32  load result, registered
- StallM  out  1  hold IF/ID/EX/EX-MEM registers and hold MEM/WB input stable
- MisalignM  out  1  misaligned-access flag, combinational
- BusErrM  out  1  timeout flag, one-cycle pulse
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write enable
- dmem_addr  out  32  word address, {ALUOutM[31:2],2'b00}
- dmem_be  out  4  byte enables, little-endian
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  bus completion
- dmem_rdata  in  32  bus read word, valid with dmem_ack

Behaviour:
- Reset (async, rst_n=0): state=IDLE, RD=0, BusErrM=0, dmem_req=0, counter=0. Takes effect immediately, including mid-transaction; dmem_req drops without waiting for ack.
- access = MemReadM|MemWriteM. If both are set, the access is a write.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. In that case:
  - MisalignM=1 and no request is issued.
  - StallM=0 and RD holds its value.
  - The state machine stays in IDLE.
- Byte enables and write data (off=addr[1:0]):
  - byte: be=0001<<off, wdata={4{WriteDataM[7:0]}}
  - half: be=0011<<off, wdata={2{WriteDataM[15:0]}}
  - word: be=1111, wdata=WriteDataM
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - aligned access present: dmem_req=1 combinationally, StallM=1, go to WAIT next edge.
  - dmem_ack=1 in this same cycle is ignored.
- WAIT:
  - dmem_req=1 and StallM=1; address, be, wdata and we stay driven from the held inputs.
  - counter increments each cycle.
  - dmem_ack=1: RD is loaded on that edge (loads only; stores leave RD unchanged), counter clears, go to DONE.
  - counter==TIMEOUT with no ack: dmem_req drops, RD=0, BusErrM is set for the DONE cycle, go to DONE.
- Load extraction from dmem_rdata:
  - byte: lane [8*off+7 : 8*off]
  - half: lane [16*off[1]+15 : 16*off[1]]
  - sign- or zero-extended per MemSignedM; word loads pass through unchanged.
- DONE:
  - dmem_req=0 and StallM=0, so the pipeline advances on this edge and MEM/WB captures RD.
  - Inputs still show the completed access; it is not re-issued.
  - Go to IDLE unconditionally; BusErrM clears.
- Ack outside WAIT is ignored.
- Latency: zero-wait memory (ack in the first WAIT cycle) gives 3 cycles of MEM occupancy, 2 of them stalled.
- Back-to-back accesses: each access sees IDLE on its first MEM cycle.
- No access in IDLE: all outputs idle, StallM=0.

Test Plan:
- Word load, addr 0x100, ack after 2 WAIT cycles, rdata 0xDEADBEEF -> dmem_be=1111; StallM high 3 cycles; RD=0xDEADBEEF in DONE; StallM=0 in DONE.
- Signed byte load, addr 0x103, rdata 0x80FF_1234 -> be=1000; RD=0xFFFFFF80. Unsigned variant -> RD=0x00000080.
- Half store, addr 0x202, WriteDataM 0x0000ABCD -> be=1100, wdata=0xABCDABCD, dmem_we=1; RD unchanged.
- Word load, addr 0x101 -> MisalignM=1, dmem_req=0, StallM=0, RD unchanged.
- No ack with TIMEOUT=4 -> dmem_req high for exactly 5 cycles (IDLE plus 4 WAIT); BusErrM=1 for 1 cycle; RD=0; FSM back in IDLE.
- rst_n low during WAIT -> dmem_req=0, StallM=0, RD=0 immediately. A late ack after reset is released is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM-stage data-memory access unit. Turns the pipeline's load/store request
// into a req/ack bus transaction, stalls the pipeline while the access is
// outstanding, and returns the aligned, extended load word as RD.
module mem_access_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] RD,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_rd;
    logic              r_busErr;

    logic              w_access;
    logic              w_isByte;
    logic              w_isHalf;
    logic              w_isWord;
    logic [1:0]        w_offset;
    logic              w_misalign;
    logic              w_inWait;
    logic              w_issue;
    logic              w_countAtLimit;
    logic              w_ackTaken;
    logic              w_timeout;
    logic              w_busDrive;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byteLane;
    logic [15:0]       w_halfLane;
    logic [31:0]       w_loadData;

    // Request decode: access kind, size class and alignment. Size 11 is
    // handled exactly like a word.
    always_comb begin
        w_access   = MemReadM | MemWriteM;
        w_isByte   = (MemSizeM == 2'b00);
        w_isHalf   = (MemSizeM == 2'b01);
        w_isWord   = MemSizeM[1];
        w_offset   = ALUOutM[1:0];
        w_misalign = (w_isHalf & ALUOutM[0]) | (w_isWord & (ALUOutM[1:0] != 2'b00));
    end

    // Transaction qualifiers. A new access is only launched from IDLE, and is
    // masked while reset is asserted so the bus goes quiet immediately even if
    // the pipeline inputs still show an access. Ack wins over the timeout if
    // both land in the same cycle.
    always_comb begin
        w_inWait       = (r_state == S_WAIT);
        w_issue        = rst_n & (r_state == S_IDLE) & w_access & ~w_misalign;
        w_countAtLimit = (r_count == TIMEOUT_CNT);
        w_ackTaken     = w_inWait & dmem_ack;
        w_timeout      = w_inWait & w_countAtLimit & ~dmem_ack;
        w_busDrive     = w_issue | w_inWait;
    end

    // Store lane steering: byte enables shifted by the byte offset and the
    // store data replicated across every lane it could land in.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
        if (w_isByte) begin
            w_be    = 4'b0001 << w_offset;
            w_wdata = {4{WriteDataM[7:0]}};
        end else if (w_isHalf) begin
            w_be    = 4'b0011 << w_offset;
            w_wdata = {2{WriteDataM[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = WriteDataM;
        end
    end

    // Load lane extraction and sign/zero extension from the bus read word.
    always_comb begin
        w_byteLane = 8'h00;
        w_halfLane = w_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_loadData = dmem_rdata;
        case (w_offset)
            2'd0:    w_byteLane = dmem_rdata[7:0];
            2'd1:    w_byteLane = dmem_rdata[15:8];
            2'd2:    w_byteLane = dmem_rdata[23:16];
            default: w_byteLane = dmem_rdata[31:24];
        endcase
        if (w_isByte) begin
            w_loadData = {{24{MemSignedM & w_byteLane[7]}}, w_byteLane};
        end else if (w_isHalf) begin
            w_loadData = {{16{MemSignedM & w_halfLane[15]}}, w_halfLane};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic: IDLE launches, WAIT ends on ack or timeout, and
    // DONE always returns to IDLE so the completed access is never re-issued.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_ackTaken || w_timeout) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // FSM outputs: request, stall and the bus fields held from the inputs for
    // the whole transaction. The request drops in the cycle the timeout fires.
    always_comb begin
        dmem_req   = 1'b0;
        StallM     = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0000_0000;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'h0000_0000;
        case (r_state)
            S_IDLE: begin
                dmem_req = w_issue;
                StallM   = w_issue;
            end
            S_WAIT: begin
                dmem_req = ~w_countAtLimit;
                StallM   = 1'b1;
            end
            default: begin
                dmem_req = 1'b0;
                StallM   = 1'b0;
            end
        endcase
        if (w_busDrive) begin
            dmem_we    = MemWriteM;
            dmem_addr  = {ALUOutM[31:2], 2'b00};
            dmem_be    = w_be;
            dmem_wdata = w_wdata;
        end
    end

    // Wait-cycle counter: counts WAIT cycles and is cleared when the access
    // finishes either way, so it is zero on entry to every WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_ackTaken || w_timeout) begin
            r_count <= '0;
        end else if (w_inWait) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

    // Load result register: captured on the ack edge for loads, forced to
    // zero on a bus timeout, otherwise held for the MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= 32'h0000_0000;
        end else if (w_ackTaken && !MemWriteM) begin
            r_rd <= w_loadData;
        end else if (w_timeout) begin
            r_rd <= 32'h0000_0000;
        end
    end

    // Bus error pulse: high exactly for the DONE cycle that follows a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busErr <= 1'b0;
        end else begin
            r_busErr <= w_timeout;
        end
    end

    // Registered and combinational flags to the pipeline.
    always_comb begin
        RD        = r_rd;
        BusErrM   = r_busErr;
        MisalignM = w_access & w_misalign;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Scoreboard bench for mem_access_stage: the driver behaves like the pipeline
// and a bus slave, pushing the expected outcome of every access; a monitor
// pops and compares whenever the stage lets the pipeline advance.
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    logic        clk;
    logic        rst_n;
    logic        MemReadM;
    logic        MemWriteM;
    logic [1:0]  MemSizeM;
    logic        MemSignedM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] RD;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        busErr;
        logic        misalign;
        int          reqCycles;
        int          stallCycles;
    } exp_t;

    exp_t        expQ[$];
    int          checks;
    int          errors;
    logic [31:0] modelRd;
    bit          scoreboardOn;

    mem_access_stage #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .MemSizeM   (MemSizeM),
        .MemSignedM (MemSignedM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .RD         (RD),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    // Free-running pipeline clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Unconditional failure for conditions that have no value to compare.
    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Reference model of one access, computed from the bus rules with plain
    // arithmetic, followed by pipeline/bus-slave driving until the stall ends.
    // ackDelay: WAIT cycle index that sees the ack, or -1 for no ack at all.
    task automatic applyStimulus(input logic rdIn, input logic wrIn, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdat, input int ackDelay);
        exp_t        e;
        int          off;
        int          cyc;
        int          guard;
        bit          mis;
        bit          timedOut;
        logic [31:0] lane;
        off = int'(addr[1:0]);
        mis = ((sz == 2'b01) && (off % 2 != 0)) || ((sz >= 2'b10) && (off != 0));
        timedOut = (ackDelay < 0) || (ackDelay >= TIMEOUT);
        e.addr = addr - 32'(off);
        e.we = wrIn;
        e.misalign = mis;
        e.busErr = 1'b0;
        if (sz == 2'b00) begin
            e.be = 4'(1 << off);
            e.wdata = 32'(wd[7:0]) * 32'h0101_0101;
        end else if (sz == 2'b01) begin
            e.be = 4'(3 << off);
            e.wdata = 32'(wd[15:0]) * 32'h0001_0001;
        end else begin
            e.be = 4'hF;
            e.wdata = wd;
        end
        if (mis) begin
            e.reqCycles = 0;
            e.stallCycles = 0;
        end else if (timedOut) begin
            e.reqCycles = 1 + TIMEOUT;
            e.stallCycles = 2 + TIMEOUT;
            e.busErr = 1'b1;
            modelRd = 32'h0;
        end else begin
            e.reqCycles = ackDelay + 2;
            e.stallCycles = ackDelay + 2;
            if (!wrIn) begin
                if (sz == 2'b00) begin
                    lane = (rdat >> (8 * off)) % 256;
                    modelRd = (sg && lane >= 128) ? lane - 256 : lane;
                end else if (sz == 2'b01) begin
                    lane = (rdat >> (8 * off)) % 65536;
                    modelRd = (sg && lane >= 32768) ? lane - 65536 : lane;
                end else begin
                    modelRd = rdat;
                end
            end
        end
        e.rd = modelRd;
        expQ.push_back(e);

        MemReadM   = rdIn;
        MemWriteM  = wrIn;
        MemSizeM   = sz;
        MemSignedM = sg;
        ALUOutM    = addr;
        WriteDataM = wd;
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        cyc = 0;
        guard = 0;
        forever begin
            @(negedge clk);
            if (!StallM) break;
            guard++;
            if (guard > 20) begin
                reportFail("stallBound");
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            dmem_ack   = (ackDelay >= 0) && (cyc == ackDelay + 1);
            dmem_rdata = dmem_ack ? rdat : $urandom;
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
    endtask

    // One pipeline bubble: no access, random junk on the other inputs.
    task automatic idleCycle();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        MemSizeM   = 2'($urandom);
        MemSignedM = 1'($urandom);
        ALUOutM    = $urandom;
        WriteDataM = $urandom;
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
    endtask

    // Randomized access: load, store or both, any size and offset.
    task automatic randomAccess();
        int          mode;
        int          dly;
        logic [31:0] a;
        mode = $urandom_range(0, 2);
        dly  = $urandom_range(0, TIMEOUT);
        if (dly == TIMEOUT) dly = -1;
        a = $urandom;
        applyStimulus(mode != 1, mode != 0, 2'($urandom), 1'($urandom), a,
                      $urandom, $urandom, dly);
    endtask

    // Monitor: counts request/stall cycles per access, checks the bus fields
    // on the first request cycle and the pipeline results when the stall ends.
    initial begin
        exp_t e;
        int   reqCnt;
        int   stallCnt;
        bit   seenReq;
        reqCnt = 0;
        stallCnt = 0;
        seenReq = 0;
        forever begin
            @(negedge clk);
            if (!scoreboardOn || !rst_n) begin
                reqCnt = 0;
                stallCnt = 0;
                seenReq = 0;
            end else if (!(MemReadM || MemWriteM)) begin
                checkOutput("idleReq", dmem_req, 0);
                checkOutput("idleStall", StallM, 0);
                checkOutput("idleBusErr", BusErrM, 0);
                checkOutput("idleRD", RD, modelRd);
            end else begin
                if (dmem_req) reqCnt++;
                if (StallM) stallCnt++;
                if (dmem_req && !seenReq) begin
                    seenReq = 1;
                    if (expQ.size() == 0) begin
                        reportFail("reqWithoutAccess");
                    end else begin
                        checkOutput("busWe", dmem_we, expQ[0].we);
                        checkOutput("busAddr", dmem_addr, expQ[0].addr);
                        checkOutput("busBe", dmem_be, expQ[0].be);
                        checkOutput("busWdata", dmem_wdata, expQ[0].wdata);
                    end
                end
                if (!StallM) begin
                    if (expQ.size() == 0) begin
                        reportFail("completeWithoutAccess");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("resultRD", RD, e.rd);
                        checkOutput("busErr", BusErrM, e.busErr);
                        checkOutput("misalign", MisalignM, e.misalign);
                        checkOutput("reqCycles", reqCnt, e.reqCycles);
                        checkOutput("stallCycles", stallCnt, e.stallCycles);
                    end
                    reqCnt = 0;
                    stallCnt = 0;
                    seenReq = 0;
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset, directed accesses, random traffic, mid-access
    // reset, recovery traffic, summary.
    initial begin
        checks = 0;
        errors = 0;
        modelRd = 32'h0;
        scoreboardOn = 0;
        rst_n = 1'b0;
        MemReadM = 1'b0;
        MemWriteM = 1'b0;
        MemSizeM = 2'b00;
        MemSignedM = 1'b0;
        ALUOutM = 32'h0;
        WriteDataM = 32'h0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetRD", RD, 0);
        checkOutput("resetReq", dmem_req, 0);
        checkOutput("resetStall", StallM, 0);
        checkOutput("resetBusErr", BusErrM, 0);
        rst_n = 1'b1;
        scoreboardOn = 1;
        idleCycle();

        applyStimulus(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1);
        applyStimulus(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        applyStimulus(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2);
        applyStimulus(0, 1, 2'b01, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 0);
        applyStimulus(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'h0, -1);
        applyStimulus(1, 0, 2'b01, 1, 32'h0000_0302, 32'h0, 32'h8001_7FFF, 3);
        idleCycle();

        for (int i = 0; i < 80; i++) begin
            randomAccess();
            if ($urandom_range(0, 3) == 0) idleCycle();
        end
        idleCycle();

        scoreboardOn = 0;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        MemSizeM   = 2'b10;
        MemSignedM = 1'b0;
        ALUOutM    = 32'h0000_0100;
        dmem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetReq", dmem_req, 0);
        checkOutput("midResetStall", StallM, 0);
        checkOutput("midResetRD", RD, 0);
        checkOutput("midResetBusErr", BusErrM, 0);
        MemReadM = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        modelRd = 32'h0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("lateAckRD", RD, 0);
            checkOutput("lateAckStall", StallM, 0);
            checkOutput("lateAckReq", dmem_req, 0);
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        scoreboardOn = 1;
        idleCycle();
        for (int i = 0; i < 10; i++) begin
            randomAccess();
        end
        idleCycle();

        checkOutput("queueDrained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
